// File: rtl/ctrl_evt_pkg.sv
// Shared types and constants for the control-level edge event block.
package ctrl_evt_pkg;

  // Glitch filter states: level settled, or a new level is being qualified.
  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } filt_state_t;

  // Bit positions inside the EDGE_MODE enable mask.
  localparam int unsigned EDGE_RISE_BIT = 0;
  localparam int unsigned EDGE_FALL_BIT = 1;

endpackage : ctrl_evt_pkg

// File: rtl/glitch_filter.sv
// Debounces an already-synchronised level. A new level must be seen on
// FILT_CYC consecutive clock edges before filt_level follows it.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ctrl_in       synchronised input level
//   filt_level    filtered level (registered)
//   rise_p_c      high in the cycle whose clock edge raises filt_level
//   fall_p_c      high in the cycle whose clock edge lowers filt_level
module glitch_filter
  import ctrl_evt_pkg::*;
#(
  parameter int unsigned FILT_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ctrl_in,
  output logic filt_level,
  output logic rise_p_c,
  output logic fall_p_c
);

  localparam int unsigned QW = $clog2(FILT_CYC + 1);

  filt_state_t   state_q, state_d;
  logic [QW-1:0] qual_cnt_q, qual_cnt_d;
  logic          filt_level_q, filt_level_d;
  logic          toggle_c;

  // State, qualification counter and filtered level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_STABLE;
      qual_cnt_q   <= '0;
      filt_level_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      qual_cnt_q   <= qual_cnt_d;
      filt_level_q <= filt_level_d;
    end
  end

  // Next-state logic; toggle_c marks the edge that accepts the new level.
  always_comb begin
    state_d      = state_q;
    qual_cnt_d   = qual_cnt_q;
    filt_level_d = filt_level_q;
    toggle_c     = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (ctrl_in != filt_level_q) begin
          if (FILT_CYC == 1) begin
            // A single sample is enough: accept immediately.
            toggle_c   = 1'b1;
            qual_cnt_d = '0;
          end else begin
            qual_cnt_d = QW'(1);
            state_d    = ST_QUAL;
          end
        end
      end
      ST_QUAL: begin
        if (ctrl_in == filt_level_q) begin
          // Input fell back before qualifying: treat as a glitch.
          qual_cnt_d = '0;
          state_d    = ST_STABLE;
        end else if (qual_cnt_q == QW'(FILT_CYC - 1)) begin
          toggle_c   = 1'b1;
          qual_cnt_d = '0;
          state_d    = ST_STABLE;
        end else begin
          qual_cnt_d = qual_cnt_q + QW'(1);
        end
      end
      default: begin
        state_d    = ST_STABLE;
        qual_cnt_d = '0;
      end
    endcase
    if (toggle_c) begin
      filt_level_d = ~filt_level_q;
    end
  end

  assign filt_level = filt_level_q;
  assign rise_p_c   = toggle_c & ~filt_level_q;
  assign fall_p_c   = toggle_c &  filt_level_q;

endmodule : glitch_filter

// File: rtl/ctrl_edge_event.sv
// Filters a synchronised control level, turns its qualified edges into
// events on a one-entry valid/ready slot, counts them and flags drops.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ctrl_in       synchronised control level
//   filt_level    debounced level
//   evt_valid     event pending; evt_rise gives its type (1 rise, 0 fall)
//   evt_ready     consumer accepts on evt_valid & evt_ready at posedge clk
//   evt_cnt       wrapping count of enabled qualified edges, drops included
//   ovf           sticky drop flag; ovf_clr clears it (a new drop wins)
module ctrl_edge_event
  import ctrl_evt_pkg::*;
#(
  parameter int unsigned FILT_CYC  = 4,
  parameter int unsigned CNT_W     = 8,
  parameter logic [1:0]  EDGE_MODE = 2'b11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_in,
  output logic             filt_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_rise,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf,
  input  logic             ovf_clr
);

  logic             rise_p_c, fall_p_c;
  logic             rise_en_c, fall_en_c, edge_c, slot_free_c;
  logic             evt_valid_q, evt_valid_d;
  logic             evt_rise_q, evt_rise_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             ovf_q, ovf_d;

  glitch_filter #(
    .FILT_CYC (FILT_CYC)
  ) u_filter (
    .clk        (clk),
    .rst        (rst),
    .ctrl_in    (ctrl_in),
    .filt_level (filt_level),
    .rise_p_c   (rise_p_c),
    .fall_p_c   (fall_p_c)
  );

  // Event slot, counter and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      evt_rise_q  <= 1'b0;
      evt_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_rise_q  <= evt_rise_d;
      evt_cnt_q   <= evt_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Slot is loadable when empty or being drained on this same edge.
  always_comb begin
    rise_en_c   = rise_p_c & EDGE_MODE[EDGE_RISE_BIT];
    fall_en_c   = fall_p_c & EDGE_MODE[EDGE_FALL_BIT];
    edge_c      = rise_en_c | fall_en_c;
    slot_free_c = ~evt_valid_q | evt_ready;

    evt_valid_d = evt_valid_q & ~evt_ready;
    evt_rise_d  = evt_rise_q;
    evt_cnt_d   = evt_cnt_q;
    ovf_d       = ovf_q & ~ovf_clr;

    if (edge_c) begin
      evt_cnt_d = evt_cnt_q + CNT_W'(1);
      if (slot_free_c) begin
        evt_valid_d = 1'b1;
        evt_rise_d  = rise_en_c;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_rise  = evt_rise_q;
  assign evt_cnt   = evt_cnt_q;
  assign ovf       = ovf_q;

endmodule : ctrl_edge_event

// File: tb/tb_ctrl_edge_event.sv
// Bench for ctrl_edge_event: dut_a uses the default configuration,
// dut_b uses FILT_CYC=1, CNT_W=2, rise-only events.
module tb_ctrl_edge_event;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       ctrl_a = 1'b0, ready_a = 1'b0, clr_a = 1'b0;
  logic       filt_a, valid_a, rise_a, ovf_a;
  logic [7:0] cnt_a;

  logic       ctrl_b = 1'b0, ready_b = 1'b0, clr_b = 1'b0;
  logic       filt_b, valid_b, rise_b, ovf_b;
  logic [1:0] cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  bit qa[$];
  bit qb[$];

  always #5 clk = ~clk;

  ctrl_edge_event #(.FILT_CYC(4), .CNT_W(8), .EDGE_MODE(2'b11)) dut_a (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_a), .filt_level(filt_a),
    .evt_valid(valid_a), .evt_ready(ready_a), .evt_rise(rise_a),
    .evt_cnt(cnt_a), .ovf(ovf_a), .ovf_clr(clr_a)
  );

  ctrl_edge_event #(.FILT_CYC(1), .CNT_W(2), .EDGE_MODE(2'b01)) dut_b (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_b), .filt_level(filt_b),
    .evt_valid(valid_b), .evt_ready(ready_b), .evt_rise(rise_b),
    .evt_cnt(cnt_b), .ovf(ovf_b), .ovf_clr(clr_b)
  );

  // Advance one clock; events accepted on this edge are scored first.
  task automatic cyc();
    bit exp;
    if (valid_a && ready_a) begin
      n_chk++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL sb_a: unexpected event rise=%0b, none expected", rise_a);
      end else begin
        exp = qa.pop_front();
        if (rise_a !== exp) begin
          n_fail++;
          $display("FAIL sb_a: evt_rise=%0b expected %0b", rise_a, exp);
        end
      end
    end
    if (valid_b && ready_b) begin
      n_chk++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_b: unexpected event rise=%0b, none expected", rise_b);
      end else begin
        exp = qb.pop_front();
        if (rise_b !== exp) begin
          n_fail++;
          $display("FAIL sb_b: evt_rise=%0b expected %0b", rise_b, exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic sb_drained(input string name);
    n_chk++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: %0d/%0d events outstanding, expected 0/0",
               name, qa.size(), qb.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ctrl_a = 0; ready_a = 0; clr_a = 0;
    ctrl_b = 0; ready_b = 0; clr_b = 0;
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({filt_a, valid_a, rise_a, cnt_a, ovf_a} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_a: filt=%0b valid=%0b rise=%0b cnt=%0d ovf=%0b expected all 0",
               filt_a, valid_a, rise_a, cnt_a, ovf_a);
    end
    n_chk++;
    if ({filt_b, valid_b, rise_b, cnt_b, ovf_b} !== 6'h00) begin
      n_fail++;
      $display("FAIL reset_b: filt=%0b valid=%0b rise=%0b cnt=%0d ovf=%0b expected all 0",
               filt_b, valid_b, rise_b, cnt_b, ovf_b);
    end
  endtask

  task automatic test_rise();
    do_reset();
    ready_a = 1; ctrl_a = 1; qa.push_back(1'b1);
    cycn(3);
    n_chk++;
    if (filt_a !== 1'b0 || valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_early: filt=%0b valid=%0b expected 0 0", filt_a, valid_a);
    end
    cyc();
    n_chk++;
    if (filt_a !== 1'b1 || valid_a !== 1'b1 || rise_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_qual: filt=%0b valid=%0b rise=%0b expected 1 1 1",
               filt_a, valid_a, rise_a);
    end
    cyc();
    n_chk++;
    if (valid_a !== 1'b0 || cnt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL rise_after: valid=%0b cnt=%0d expected 0 1", valid_a, cnt_a);
    end
    cycn(5);
    n_chk++;
    if (filt_a !== 1'b1 || valid_a !== 1'b0 || cnt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL rise_hold: filt=%0b valid=%0b cnt=%0d expected 1 0 1",
               filt_a, valid_a, cnt_a);
    end
    sb_drained("rise");
  endtask

  task automatic test_glitch();
    do_reset();
    ready_a = 1; ctrl_a = 1;
    cycn(3);
    ctrl_a = 0;
    cycn(6);
    n_chk++;
    if (filt_a !== 1'b0 || valid_a !== 1'b0 || cnt_a !== 8'd0) begin
      n_fail++;
      $display("FAIL glitch: filt=%0b valid=%0b cnt=%0d expected 0 0 0",
               filt_a, valid_a, cnt_a);
    end
    sb_drained("glitch");
  endtask

  task automatic test_overflow();
    do_reset();
    ctrl_a = 1; qa.push_back(1'b1);
    cycn(4);
    ctrl_a = 0;
    cycn(4);
    n_chk++;
    if (valid_a !== 1'b1 || rise_a !== 1'b1 || ovf_a !== 1'b1 || cnt_a !== 8'd2) begin
      n_fail++;
      $display("FAIL ovf_drop: valid=%0b rise=%0b ovf=%0b cnt=%0d expected 1 1 1 2",
               valid_a, rise_a, ovf_a, cnt_a);
    end
    clr_a = 1;
    cyc();
    clr_a = 0;
    n_chk++;
    if (ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: ovf=%0b expected 0", ovf_a);
    end
    ctrl_a = 1;
    cycn(3);
    clr_a = 1;
    cyc();
    clr_a = 0;
    n_chk++;
    if (ovf_a !== 1'b1 || cnt_a !== 8'd3 || rise_a !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: ovf=%0b cnt=%0d rise=%0b expected 1 3 1",
               ovf_a, cnt_a, rise_a);
    end
    ready_a = 1;
    cyc();
    n_chk++;
    if (valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_accept: valid=%0b expected 0", valid_a);
    end
    sb_drained("overflow");
  endtask

  task automatic test_back_to_back();
    do_reset();
    ctrl_a = 1; qa.push_back(1'b1);
    cycn(4);
    ctrl_a = 0; qa.push_back(1'b0);
    cycn(3);
    ready_a = 1;
    cyc();
    ready_a = 0;
    n_chk++;
    if (valid_a !== 1'b1 || rise_a !== 1'b0 || ovf_a !== 1'b0 || cnt_a !== 8'd2) begin
      n_fail++;
      $display("FAIL b2b: valid=%0b rise=%0b ovf=%0b cnt=%0d expected 1 0 0 2",
               valid_a, rise_a, ovf_a, cnt_a);
    end
    ready_a = 1;
    cyc();
    ready_a = 0;
    sb_drained("back_to_back");
  endtask

  task automatic test_mode_wrap();
    do_reset();
    ready_b = 1;
    ctrl_b = 1; qb.push_back(1'b1);
    cyc();
    n_chk++;
    if (filt_b !== 1'b1 || valid_b !== 1'b1 || rise_b !== 1'b1) begin
      n_fail++;
      $display("FAIL fast_rise: filt=%0b valid=%0b rise=%0b expected 1 1 1",
               filt_b, valid_b, rise_b);
    end
    ctrl_b = 0;
    cyc();
    n_chk++;
    if (filt_b !== 1'b0 || valid_b !== 1'b0 || cnt_b !== 2'd1) begin
      n_fail++;
      $display("FAIL fall_disabled: filt=%0b valid=%0b cnt=%0d expected 0 0 1",
               filt_b, valid_b, cnt_b);
    end
    for (int i = 0; i < 4; i++) begin
      ctrl_b = 1; qb.push_back(1'b1);
      cyc();
      ctrl_b = 0;
      cyc();
    end
    n_chk++;
    if (cnt_b !== 2'd1 || ovf_b !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: cnt=%0d ovf=%0b expected 1 0", cnt_b, ovf_b);
    end
    sb_drained("mode_wrap");
  endtask

  task automatic test_reset_mid();
    do_reset();
    ctrl_a = 1;
    cycn(4);
    ctrl_a = 0;
    cycn(2);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({filt_a, valid_a, rise_a, cnt_a, ovf_a} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid: filt=%0b valid=%0b rise=%0b cnt=%0d ovf=%0b expected all 0",
               filt_a, valid_a, rise_a, cnt_a, ovf_a);
    end
    ctrl_a = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.push_back(1'b1);
    cycn(3);
    n_chk++;
    if (filt_a !== 1'b0 || valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rel_early: filt=%0b valid=%0b expected 0 0", filt_a, valid_a);
    end
    cyc();
    n_chk++;
    if (filt_a !== 1'b1 || valid_a !== 1'b1 || rise_a !== 1'b1 || cnt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_rel_rise: filt=%0b valid=%0b rise=%0b cnt=%0d expected 1 1 1 1",
               filt_a, valid_a, rise_a, cnt_a);
    end
    ready_a = 1;
    cyc();
    sb_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_mode_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_ctrl_edge_event
